// File: rtl/reset_pkg.sv
// Shared types for the system reset sequencer.
package reset_pkg;

    typedef enum logic [1:0] {
        ST_HOLD       = 2'd0,
        ST_WAIT_LOCK  = 2'd1,
        ST_REL_PERIPH = 2'd2,
        ST_RUN        = 2'd3
    } rst_state_t;

    localparam int RESET_COUNT_WIDTH = 8;

endpackage

// File: rtl/reset_sequencer.sv
// System reset sequencer: holds resets until PLL lock is stable, then releases
// peripherals first and the CPU a fixed gap later. Re-enters on lock loss or soft reset.
//
// state         | meaning
// ST_HOLD       | unconditional hold, both resets asserted
// ST_WAIT_LOCK  | counting consecutive locked cycles, both resets asserted
// ST_REL_PERIPH | peripheral reset released, CPU still held
// ST_RUN        | both resets released
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int HOLD_CYCLES        = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP_CYCLES   = 8
) (
    input  logic                         clk_in,
    input  logic                         reset_in,
    input  logic                         locked_in,
    input  logic                         soft_reset_in,
    output logic                         periph_reset_n_out,
    output logic                         cpu_reset_n_out,
    output logic [1:0]                   state_out,
    output logic [RESET_COUNT_WIDTH-1:0] reset_count_out
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > LOCK_STABLE_CYCLES)
                              ? ((HOLD_CYCLES > STAGE_GAP_CYCLES) ? HOLD_CYCLES : STAGE_GAP_CYCLES)
                              : ((LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ? LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES);
    localparam int CW = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP_CYCLES - 1);

    if (HOLD_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || STAGE_GAP_CYCLES < 1) begin : g_param_check
        $error("reset_sequencer: cycle parameters must be >= 1");
    end

    rst_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort;
    logic          count_inc;

    // Lock loss only aborts once released; HOLD ignores it and WAIT_LOCK just restarts its count.
    assign abort = soft_reset_in || !locked_in;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        count_inc = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (soft_reset_in) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (soft_reset_in) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else if (!locked_in) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_REL_PERIPH;
                    cnt_d   = '0;
                end
            end
            ST_REL_PERIPH: begin
                if (abort) begin
                    state_d   = ST_HOLD;
                    cnt_d     = '0;
                    count_inc = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (abort) begin
                    state_d   = ST_HOLD;
                    count_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q            <= ST_HOLD;
            cnt_q              <= '0;
            periph_reset_n_out <= 1'b0;
            cpu_reset_n_out    <= 1'b0;
            reset_count_out    <= '0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            periph_reset_n_out <= (state_d == ST_REL_PERIPH) || (state_d == ST_RUN);
            cpu_reset_n_out    <= (state_d == ST_RUN);
            if (count_inc && (reset_count_out != {RESET_COUNT_WIDTH{1'b1}})) begin
                reset_count_out <= reset_count_out + 1'b1;
            end
        end
    end

    assign state_out = state_q;

    a_reset_order : assert property (@(posedge clk_in) disable iff (!reset_in)
        !(cpu_reset_n_out && !periph_reset_n_out));

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed release-timing checks plus randomized
// lock/soft-reset traffic compared every cycle against a behavioural model.
module tb_reset_sequencer;

    localparam int HOLD = 4;
    localparam int LOCK = 8;
    localparam int GAP  = 2;

    logic       clk_in        = 1'b0;
    logic       reset_in      = 1'b0;
    logic       locked_in     = 1'b1;
    logic       soft_reset_in = 1'b0;
    logic       periph_reset_n_out;
    logic       cpu_reset_n_out;
    logic [1:0] state_out;
    logic [7:0] reset_count_out;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    logic cmp_en = 1'b0;

    reset_sequencer #(
        .HOLD_CYCLES       (HOLD),
        .LOCK_STABLE_CYCLES(LOCK),
        .STAGE_GAP_CYCLES  (GAP)
    ) dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .locked_in         (locked_in),
        .soft_reset_in     (soft_reset_in),
        .periph_reset_n_out(periph_reset_n_out),
        .cpu_reset_n_out   (cpu_reset_n_out),
        .state_out         (state_out),
        .reset_count_out   (reset_count_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) edge_n <= edge_n + 1;

    // Behavioural model: phase plus elapsed cycles in that phase, and an abort tally.
    int m_phase = 0;
    int m_held = 0;
    int m_locked_run = 0;
    int m_gap = 0;
    int m_aborts = 0;

    always @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            m_phase      <= 0;
            m_held       <= 0;
            m_locked_run <= 0;
            m_gap        <= 0;
            m_aborts     <= 0;
        end else if (m_phase == 0) begin
            if (soft_reset_in) m_held <= 0;
            else if (m_held + 1 >= HOLD) begin
                m_phase      <= 1;
                m_held       <= 0;
                m_locked_run <= 0;
            end else m_held <= m_held + 1;
        end else if (m_phase == 1) begin
            if (soft_reset_in) begin
                m_phase <= 0;
                m_held  <= 0;
            end else if (!locked_in) m_locked_run <= 0;
            else if (m_locked_run + 1 >= LOCK) begin
                m_phase <= 2;
                m_gap   <= 0;
            end else m_locked_run <= m_locked_run + 1;
        end else begin
            if (soft_reset_in || !locked_in) begin
                m_phase  <= 0;
                m_held   <= 0;
                m_aborts <= (m_aborts >= 255) ? 255 : m_aborts + 1;
            end else if (m_phase == 2) begin
                if (m_gap + 1 >= GAP) m_phase <= 3;
                else m_gap <= m_gap + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (cmp_en) begin
            chk("model_periph", int'(periph_reset_n_out), (m_phase >= 2) ? 1 : 0);
            chk("model_cpu", int'(cpu_reset_n_out), (m_phase == 3) ? 1 : 0);
            chk("model_state", int'(state_out), m_phase);
            chk("model_count", int'(reset_count_out), m_aborts);
            chk("order", int'(cpu_reset_n_out && !periph_reset_n_out), 0);
        end
    end

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    // Returns the edge number at which the selected reset output was seen high, or -1 on timeout.
    task automatic wait_high(input bit cpu, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 300) begin
            if ((cpu ? cpu_reset_n_out : periph_reset_n_out) === 1'b1) begin
                at = edge_n;
                break;
            end
            tick();
            n++;
        end
        if (at < 0) chk(cpu ? "wait_cpu_timeout" : "wait_periph_timeout", 0, 1);
    endtask

    task automatic restart(input logic lock_level);
        reset_in  = 1'b0;
        locked_in = lock_level;
        soft_reset_in = 1'b0;
        tick();
        tick();
        reset_in = 1'b1;
        edge_n   = 0;
    endtask

    task automatic soft_pulse();
        soft_reset_in = 1'b1;
        tick();
        soft_reset_in = 1'b0;
    endtask

    initial begin
        int at, e0;
        tick();
        tick();
        cmp_en = 1'b1;
        chk("reset_periph", int'(periph_reset_n_out), 0);
        chk("reset_cpu", int'(cpu_reset_n_out), 0);
        chk("reset_state", int'(state_out), 0);
        chk("reset_count", int'(reset_count_out), 0);

        // Nominal power-up with stable lock.
        restart(1'b1);
        wait_high(1'b0, at);
        chk("pwr_periph_edge", at, HOLD + LOCK);
        wait_high(1'b1, at);
        chk("pwr_cpu_edge", at, HOLD + LOCK + GAP);
        chk("pwr_state", int'(state_out), 3);
        chk("pwr_count", int'(reset_count_out), 0);

        // Lock arrives late: low through edge 5.
        restart(1'b0);
        repeat (5) tick();
        locked_in = 1'b1;
        wait_high(1'b0, at);
        chk("late_lock_periph_edge", at, 13);

        // One-cycle lock glitch at WAIT_LOCK count 6.
        restart(1'b1);
        repeat (10) tick();
        locked_in = 1'b0;
        tick();
        locked_in = 1'b1;
        wait_high(1'b0, at);
        chk("glitch_periph_edge", at, 19);
        chk("glitch_count", int'(reset_count_out), 0);
        wait_high(1'b1, at);

        // Soft reset from RUN.
        soft_pulse();
        e0 = edge_n;
        chk("soft_periph_low", int'(periph_reset_n_out), 0);
        chk("soft_cpu_low", int'(cpu_reset_n_out), 0);
        chk("soft_state", int'(state_out), 0);
        chk("soft_count", int'(reset_count_out), 1);
        wait_high(1'b0, at);
        chk("soft_periph_delay", at - e0, 12);
        wait_high(1'b1, at);
        chk("soft_cpu_delay", at - e0, 14);

        // Soft reset coincident with lock loss counts once.
        soft_reset_in = 1'b1;
        locked_in     = 1'b0;
        tick();
        soft_reset_in = 1'b0;
        locked_in     = 1'b1;
        chk("dual_abort_count", int'(reset_count_out), 2);
        wait_high(1'b1, at);

        // Held soft reset: one increment only.
        soft_reset_in = 1'b1;
        repeat (4) tick();
        soft_reset_in = 1'b0;
        chk("held_soft_count", int'(reset_count_out), 3);
        chk("held_soft_state", int'(state_out), 0);
        wait_high(1'b1, at);

        // Saturation.
        for (int i = 0; i < 300; i++) begin
            soft_pulse();
            wait_high(1'b1, at);
        end
        chk("sat_count", int'(reset_count_out), 255);

        // Asynchronous reset in the middle of REL_PERIPH.
        soft_pulse();
        wait_high(1'b0, at);
        #2;
        reset_in = 1'b0;
        #1;
        chk("async_periph", int'(periph_reset_n_out), 0);
        chk("async_cpu", int'(cpu_reset_n_out), 0);
        chk("async_state", int'(state_out), 0);
        chk("async_count", int'(reset_count_out), 0);
        tick();
        reset_in = 1'b1;

        // Randomized lock drops, soft resets and occasional async resets.
        for (int i = 0; i < 5000; i++) begin
            if ((i / 500) % 2 == 0) locked_in = ($urandom_range(0, 99) < 97);
            else locked_in = ($urandom_range(0, 99) < 99);
            soft_reset_in = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2;
                reset_in = 1'b0;
                #1;
                reset_in = 1'b1;
            end
            tick();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Owns system reset generation for the Arty A7 top level. Replaces the ad-hoc `~reset_rising & locked` term.
- Holds all logic in reset until the PLL lock has been stable for a programmable time, then releases peripheral reset first and CPU/core reset a fixed gap later.
- Re-enters the reset sequence on loss of lock or on a soft-reset pulse (debounced button rising edge).
- Runs in the slow PLL clock domain; outputs are registered, active-low resets for downstream logic.

Parameters:
- HOLD_CYCLES, 16: minimum cycles resets stay asserted on every sequence entry; must be >= 1.
- LOCK_STABLE_CYCLES, 1024: consecutive cycles `locked_in` must be high before release; must be >= 1.
- STAGE_GAP_CYCLES, 8: cycles between peripheral release and CPU release; must be >= 1.

Ports:
- clk_in  input  1  slow system clock (PLL output)
- reset_in  input  1  asynchronous, active-low reset
- locked_in  input  1  PLL locked indication
- soft_reset_in  input  1  single-cycle request pulse (debouncer rising-edge output), already synchronous to clk_in
- periph_reset_n_out  output  1  active-low reset for peripherals/LED logic
- cpu_reset_n_out  output  1  active-low reset for core
- state_out  output  2  current sequencer state (rst_state_t encoding)
- reset_count_out  output  8  saturating count of re-entries from released states

Behaviour:
- Reset values while `reset_in` low, applied asynchronously:
  - state = ST_HOLD, cnt = 0
  - periph_reset_n_out = 0, cpu_reset_n_out = 0
  - reset_count_out = 0
- All outputs are registered. Each reset output is decoded from the next state, so it changes on the same edge that enters a state.
- Counter `cnt` width is $clog2 of the largest parameter, plus 1. It is cleared on every state change.
- ST_HOLD (0): both resets asserted. cnt increments each cycle. When cnt == HOLD_CYCLES-1, go to ST_WAIT_LOCK. Duration is exactly HOLD_CYCLES cycles, independent of `locked_in`.
- ST_WAIT_LOCK (1): both resets asserted.
  - `locked_in` high: cnt increments.
  - `locked_in` low: cnt clears to 0 (the count must be consecutive).
  - When locked_in && cnt == LOCK_STABLE_CYCLES-1, go to ST_REL_PERIPH.
- ST_REL_PERIPH (2): periph_reset_n_out = 1, cpu_reset_n_out = 0. cnt increments. When cnt == STAGE_GAP_CYCLES-1, go to ST_RUN.
- ST_RUN (3): both resets deasserted. Stays here until an abort event.
- Abort events are `soft_reset_in` == 1, or `locked_in` == 0 while in ST_REL_PERIPH or ST_RUN.
  - On an abort: next state = ST_HOLD, cnt = 0, and both resets are asserted on that same edge (one-cycle latency from event to assertion).
  - From ST_REL_PERIPH or ST_RUN, an abort increments reset_count_out, saturating at 255.
- `soft_reset_in` in ST_HOLD restarts the hold: cnt = 0, no count increment.
- `soft_reset_in` in ST_WAIT_LOCK returns to ST_HOLD: cnt = 0, no count increment.
- `soft_reset_in` and a lock loss in the same cycle are one abort: count +1 once.
- `soft_reset_in` held high for several cycles keeps the block in ST_HOLD with cnt = 0. The count increments only on the first cycle.
- A lock loss during ST_HOLD is ignored, because the hold is unconditional. ST_WAIT_LOCK then enforces stability.
- Asserting `reset_in` at any point, including mid-sequence, returns immediately to reset values.
- Glitch-free outputs: cpu_reset_n_out is never 1 while periph_reset_n_out is 0.
- Simulation-only checks:
  - parameters >= 1, via elaboration-time assertion;
  - the ordering property above, via a concurrent assertion.
- Nominal release latency from `reset_in` rising, with lock already stable:
  - periph_reset_n_out rises at edge HOLD_CYCLES + LOCK_STABLE_CYCLES;
  - cpu_reset_n_out rises STAGE_GAP_CYCLES edges later.

Decomposition:
- Package `reset_pkg`:
  - `rst_state_t` (2-bit enum: ST_HOLD, ST_WAIT_LOCK, ST_REL_PERIPH, ST_RUN);
  - `RESET_COUNT_WIDTH` = 8.
- No sub-module. The single FSM plus counter is natural.
- The top level instantiates `synchronizer` and `debouncer` ahead of this block and feeds `is_rising_out` to `soft_reset_in`.

Test Plan:
- Use HOLD=4, LOCK=8, GAP=2 throughout.
- Power-up with locked_in=1 throughout, reset_in released at edge 0 -> periph_reset_n_out rises at edge 12, cpu_reset_n_out at edge 14, state_out=3, reset_count_out=0.
- locked_in low for edges 0-5, then high -> WAIT_LOCK counts from the first high cycle. periph rises 8 edges after locked_in goes high (never before edge 12).
- locked_in glitch low for 1 cycle at WAIT_LOCK cnt=6 -> cnt clears; release is delayed by 7 more cycles; reset_count_out stays 0.
- In ST_RUN, pulse soft_reset_in for 1 cycle -> both resets low on the next edge, state_out=0, reset_count_out=1. Re-release occurs 12 and 14 edges later.
- In ST_RUN, soft_reset_in and locked_in drop in the same cycle -> reset_count_out increments by exactly 1.
- Issue 300 soft resets from ST_RUN -> reset_count_out saturates at 255.
- Assert reset_in low mid ST_REL_PERIPH -> both resets low, state_out=0, and reset_count_out=0 immediately, with no clock edge.
